// File: rtl/seq_squarer.sv
// seq_squarer: multi-cycle unsigned squarer built on an iterative shift-add datapath.
// An operand is accepted with a valid/ready handshake and squared over exactly WIDTH cycles.
// The result is then held until the downstream handshake completes.
//
// Optional feature: define SEQ_SQUARER_SIGNED_EN to treat in_data as two's complement.
// The square is then taken of |in_data|, so the result is always non-negative.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand on in_data is valid
//   in_data    WIDTH-bit operand
//   in_ready   block can accept an operand (high only in IDLE)
//   out_valid  out_data holds a completed square
//   out_data   2*WIDTH-bit squared result
//   out_ready  downstream accepts the result
//   busy       high while computing or holding a result
module seq_squarer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_data,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned OUT_W = 2 * WIDTH;
  localparam int unsigned CNT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [OUT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_busy;

  logic [WIDTH-1:0]   w_operand;
  logic [OUT_W-1:0]   w_sum;

  // Operand fed into both multiplicand and multiplier.
`ifdef SEQ_SQUARER_SIGNED_EN
  // The most negative value negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
  assign w_operand = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
`else
  assign w_operand = in_data;
`endif

  // Partial product for the current multiplier bit. The sum cannot overflow 2*WIDTH bits.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= OUT_W'(w_operand);
            r_mplier   <= w_operand;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          // Fixed WIDTH iterations, so the latency does not depend on the data.
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready returns one cycle after the output handshake, so accept never overlaps it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_squarer.sv
// Testbench for seq_squarer. The main instance uses WIDTH=8.
// Two small instances (WIDTH=3 and WIDTH=4) are used for the exhaustive sweeps.
module tb_seq_squarer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, ordy8, busy8;
  logic [7:0]  id8;
  logic [15:0] od8;
  logic        iv3, ir3, ov3, ordy3, busy3;
  logic [2:0]  id3;
  logic [5:0]  od3;
  logic        iv4, ir4, ov4, ordy4, busy4;
  logic [3:0]  id4;
  logic [7:0]  od4;

  int n_chk = 0;
  int n_err = 0;

  seq_squarer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_data(id8), .in_ready(ir8),
    .out_valid(ov8), .out_data(od8), .out_ready(ordy8), .busy(busy8)
  );
  seq_squarer #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(ordy3), .busy(busy3)
  );
  seq_squarer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(ordy4), .busy(busy4)
  );

  // Reference: square of the operand, or of its magnitude in the signed build.
  function automatic longint unsigned ref_sq(input longint unsigned x, input int w);
    longint unsigned m;
    m = x;
`ifdef SEQ_SQUARER_SIGNED_EN
    if (((x >> (w - 1)) & 64'd1) == 64'd1) m = (64'd1 << w) - x;
`else
    if (w < 0) m = 0;
`endif
    return m * m;
  endfunction

  // Runs one transaction on dut8. The result is held for `hold` cycles before out_ready rises.
  // The task returns just after the handshake edge. lat = -1 means out_valid never came.
  task automatic do_op8(input logic [7:0] x, input int hold, output logic [15:0] res,
                        output int lat, output bit side_ok);
    int guard;
    side_ok = 1'b1;
    lat = -1;
    res = '0;
    guard = 0;
    while (!ir8 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    iv8 = 1'b1;
    id8 = x;
    ordy8 = (hold == 0);
    @(negedge clk);
    iv8 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ov8) begin
        lat = n;
        break;
      end
      if (ir8 || !busy8) side_ok = 1'b0;
      @(negedge clk);
    end
    if (lat < 0) begin
      ordy8 = 1'b1;
      return;
    end
    res = od8;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!ov8 || !busy8 || ir8 || od8 !== res) side_ok = 1'b0;
    end
    ordy8 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({ir8, ov8, busy8} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100", {ir8, ov8, busy8});
    end
    n_chk++;
    if (od8 !== 16'd0) begin
      n_err++; $display("FAIL reset_data: got %0d want 0", od8);
    end
    n_chk++;
    if ({ir3, ov3, busy3, ir4, ov4, busy4} !== 6'b100100) begin
      n_err++; $display("FAIL reset_small: got %b want 100100", {ir3, ov3, busy3, ir4, ov4, busy4});
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ir8, ov8, busy8} !== 3'b100) begin
      n_err++; $display("FAIL reset_release: got %b want 100", {ir8, ov8, busy8});
    end
  endtask

  task automatic test_small_values;
    logic [15:0] res;
    int lat;
    bit ok;
    for (int v = 0; v < 2; v++) begin
      do_op8(8'(v), 0, res, lat, ok);
      n_chk++;
      if (lat != 8) begin
        n_err++; $display("FAIL small_latency: in=%0d got %0d want 8", v, lat);
      end
      n_chk++;
      if (res !== 16'(v)) begin
        n_err++; $display("FAIL small_result: in=%0d got %0d want %0d", v, res, v);
      end
      n_chk++;
      if (!ok || {ir8, ov8, busy8} !== 3'b100) begin
        n_err++; $display("FAIL small_ctrl: in=%0d got ok=%0d ctrl=%b want ok=1 ctrl=100", v, ok, {ir8, ov8, busy8});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r [2];
    int t_out [2];
    int cyc, k, ir_hi;
    r[0] = '0; r[1] = '0; t_out[0] = 0; t_out[1] = 0;
    iv8 = 1'b1;
    id8 = 8'd13;
    ordy8 = 1'b1;
    @(negedge clk);
    id8 = 8'd255;    // next operand presented while the first one is still computing
    cyc = 0; k = 0; ir_hi = 0;
    while (k < 2 && cyc < 60) begin
      if (ov8) begin
        r[k] = od8; t_out[k] = cyc; k++;
      end else if (ir8) begin
        ir_hi += (k == 1) ? 1 : 100;
      end
      @(negedge clk);
      cyc++;
    end
    iv8 = 1'b0;
    n_chk++;
    if (k != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d want 2", k);
    end
    n_chk++;
    if (r[0] !== 16'(ref_sq(13, 8))) begin
      n_err++; $display("FAIL b2b_first: got %0d want %0d", r[0], ref_sq(13, 8));
    end
    n_chk++;
    if (r[1] !== 16'(ref_sq(255, 8))) begin
      n_err++; $display("FAIL b2b_second: got %0d want %0d", r[1], ref_sq(255, 8));
    end
    n_chk++;
    if (t_out[1] - t_out[0] != 10) begin
      n_err++; $display("FAIL b2b_period: got %0d want 10", t_out[1] - t_out[0]);
    end
    n_chk++;
    if (ir_hi != 1) begin
      n_err++; $display("FAIL b2b_in_ready: got %0d want 1", ir_hi);
    end
  endtask

  task automatic test_stall;
    logic [15:0] res;
    int lat;
    bit ok;
    do_op8(8'd7, 5, res, lat, ok);
    n_chk++;
    if (lat != 8 || res !== 16'd49) begin
      n_err++; $display("FAIL stall_result: got lat=%0d res=%0d want lat=8 res=49", lat, res);
    end
    n_chk++;
    if (!ok) begin
      n_err++; $display("FAIL stall_hold: got %0d want 1", ok);
    end
    n_chk++;
    if ({ir8, ov8, busy8} !== 3'b100) begin
      n_err++; $display("FAIL stall_release: got %b want 100", {ir8, ov8, busy8});
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [15:0] res;
    int lat;
    bit ok;
    iv8 = 1'b1; id8 = 8'd200; ordy8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    iv8 = 1'b1;      // valid during reset must not be accepted
    @(negedge clk);
    n_chk++;
    if ({ir8, ov8, busy8} !== 3'b100 || od8 !== 16'd0) begin
      n_err++; $display("FAIL rst_calc: got ctrl=%b data=%0d want ctrl=100 data=0", {ir8, ov8, busy8}, od8);
    end
    @(negedge clk);
    rst = 1'b0;
    iv8 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy8 !== 1'b0) begin
      n_err++; $display("FAIL rst_wins: got busy=%b want 0", busy8);
    end
    do_op8(8'd3, 0, res, lat, ok);
    n_chk++;
    if (lat != 8 || res !== 16'd9) begin
      n_err++; $display("FAIL rst_after_op: got lat=%0d res=%0d want lat=8 res=9", lat, res);
    end
  endtask

  task automatic test_reset_in_done;
    int guard;
    iv8 = 1'b1; id8 = 8'd21; ordy8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    guard = 0;
    while (!ov8 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (ov8 !== 1'b1 || od8 !== 16'(ref_sq(21, 8))) begin
      n_err++; $display("FAIL done_before_rst: got ov=%b data=%0d want ov=1 data=%0d", ov8, od8, ref_sq(21, 8));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({ir8, ov8, busy8} !== 3'b100 || od8 !== 16'd0) begin
      n_err++; $display("FAIL rst_done: got ctrl=%b data=%0d want ctrl=100 data=0", {ir8, ov8, busy8}, od8);
    end
    ordy8 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edge_values;
    logic [7:0] vals [3];
    logic [15:0] res;
    int lat;
    bit ok;
    vals[0] = 8'h80; vals[1] = 8'hFF; vals[2] = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      do_op8(vals[i], 0, res, lat, ok);
      n_chk++;
      if (lat != 8 || res !== 16'(ref_sq(64'(vals[i]), 8))) begin
        n_err++; $display("FAIL edge_value: in=%0h got lat=%0d res=%0d want lat=8 res=%0d", vals[i], lat, res, ref_sq(64'(vals[i]), 8));
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] x;
    logic [15:0] res;
    int lat, hold;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom_range(0, 255));
      hold = int'($urandom_range(0, 3));
      do_op8(x, hold, res, lat, ok);
      n_chk++;
      if (lat != 8 || res !== 16'(ref_sq(64'(x), 8)) || !ok || {ir8, ov8} !== 2'b10) begin
        n_err++; $display("FAIL random_op: in=%0d hold=%0d got lat=%0d res=%0d ok=%0d want lat=8 res=%0d ok=1", x, hold, lat, res, ok, ref_sq(64'(x), 8));
      end
    end
  endtask

  task automatic test_sweep;
    int lat3, lat4;
    logic [5:0] r3;
    logic [7:0] r4;
    for (int i = 0; i < 16; i++) begin
      iv3 = (i < 8); id3 = 3'(i);
      iv4 = 1'b1;    id4 = 4'(i);
      @(negedge clk);
      iv3 = 1'b0; iv4 = 1'b0;
      lat3 = -1; lat4 = -1; r3 = '0; r4 = '0;
      for (int n = 0; n < 20; n++) begin
        if (ov3 && lat3 < 0) begin lat3 = n; r3 = od3; end
        if (ov4 && lat4 < 0) begin lat4 = n; r4 = od4; end
        if (lat4 >= 0 && (lat3 >= 0 || i >= 8)) break;
        @(negedge clk);
      end
      @(negedge clk);
      if (i < 8) begin
        n_chk++;
        if (lat3 != 3 || r3 !== 6'(ref_sq(64'(i), 3))) begin
          n_err++; $display("FAIL sweep_w3: in=%0d got lat=%0d res=%0d want lat=3 res=%0d", i, lat3, r3, ref_sq(64'(i), 3));
        end
      end
      n_chk++;
      if (lat4 != 4 || r4 !== 8'(ref_sq(64'(i), 4))) begin
        n_err++; $display("FAIL sweep_w4: in=%0d got lat=%0d res=%0d want lat=4 res=%0d", i, lat4, r4, ref_sq(64'(i), 4));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; id8 = '0; ordy8 = 1'b1;
    iv3 = 1'b0; id3 = '0; ordy3 = 1'b1;
    iv4 = 1'b0; id4 = '0; ordy4 = 1'b1;
    @(negedge clk);
    test_reset();
    test_small_values();
    test_back_to_back();
    test_stall();
    test_reset_mid_calc();
    test_reset_in_done();
    test_edge_values();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
